// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and helpers for the memory-stage to Wishbone data-bus bridge.
package dmem_bus_bridge_pkg;

   localparam int unsigned REG_DATA_BUS = 32;
   localparam logic [REG_DATA_BUS-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      HOLD = 2'b10
   } bus_state_t;

   // Bus addresses are word aligned; byte position is carried by the selects.
   function automatic logic [REG_DATA_BUS-1:0] word_align(input logic [REG_DATA_BUS-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/dmem_bus_bridge_timeout_cnt.sv
// Counts BUSY cycles of one bus access; expire flags the last permitted cycle.
module dmem_bus_bridge_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_reg;

   // Saturates on the expiry value so a late terminate can never wrap it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         timer_reg <= '0;
      end else if (enable && (timer_reg != LAST)) begin
         timer_reg <= timer_reg + TW'(1);
      end
   end

   assign expire = (timer_reg == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Runs the memory stage's single-cycle RAM request as a Wishbone-classic master
// cycle, stalling the pipeline until ack, error, timeout or flush.
module dmem_bus_bridge
   import dmem_bus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        bus_err_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   bus_state_t state_reg, state_next;
   logic [31:0] rdata_reg;
   logic        issue, done_ack, done_err, expire;

   dmem_bus_bridge_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_reg != BUSY),
      .enable (state_reg == BUSY),
      .expire (expire)
   );

   always_comb begin
      state_next = state_reg;
      stallreq_o = 1'b0;
      cpu_data_o = rdata_reg;
      issue      = 1'b0;
      done_ack   = 1'b0;
      done_err   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stallreq_o = 1'b1;
               issue      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            // Flush outranks every termination: the access is simply abandoned.
            if (flush_i) begin
               state_next = IDLE;
            end else if (wb_ack_i) begin
               done_ack   = 1'b1;
               if (!wb_we_o) cpu_data_o = wb_dat_i;
               state_next = stall_i ? HOLD : IDLE;
            end else if (wb_err_i || expire) begin
               done_err   = 1'b1;
               cpu_data_o = ZERO_WORD;
               state_next = stall_i ? HOLD : IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
         end
         HOLD: begin
            // Parks here so a frozen pipeline cannot re-issue the finished access.
            if (!stall_i || flush_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         rdata_reg <= ZERO_WORD;
         bus_err_o <= 1'b0;
         wb_adr_o  <= ZERO_WORD;
         wb_dat_o  <= ZERO_WORD;
         wb_sel_o  <= 4'b0000;
         wb_we_o   <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
      end else begin
         state_reg <= state_next;
         bus_err_o <= done_err;
         if (issue) begin
            wb_adr_o <= word_align(cpu_addr_i);
            wb_dat_o <= cpu_data_i;
            wb_sel_o <= cpu_sel_i;
            wb_we_o  <= cpu_we_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
         end else if (state_next != BUSY) begin
            wb_adr_o <= ZERO_WORD;
            wb_dat_o <= ZERO_WORD;
            wb_sel_o <= 4'b0000;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
         end
         if (done_ack && !wb_we_o) begin
            rdata_reg <= wb_dat_i;
         end else if (done_err) begin
            rdata_reg <= ZERO_WORD;
         end
      end
   end

endmodule
